// File: rtl/piano_pkg.sv
// Shared keyboard tone-section constants: key/voice counts, note indices and the
// half-period table the voice generators use (clk_sys cycles at 100 MHz).
package piano_pkg;

  localparam int NUM_KEYS   = 21;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = 5;
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int HALF_W     = 19;

  // White-key note indices, three octaves from C3.
  localparam logic [KEY_W-1:0] C3 = 5'd0,  D3 = 5'd1,  E3 = 5'd2,  F3 = 5'd3;
  localparam logic [KEY_W-1:0] G3 = 5'd4,  A3 = 5'd5,  B3 = 5'd6;
  localparam logic [KEY_W-1:0] C4 = 5'd7,  D4 = 5'd8,  E4 = 5'd9,  F4 = 5'd10;
  localparam logic [KEY_W-1:0] G4 = 5'd11, A4 = 5'd12, B4 = 5'd13;
  localparam logic [KEY_W-1:0] C5 = 5'd14, D5 = 5'd15, E5 = 5'd16, F5 = 5'd17;
  localparam logic [KEY_W-1:0] G5 = 5'd18, A5 = 5'd19, B5 = 5'd20;

  // 100 MHz / (2 * f), indexed by note index.
  localparam logic [HALF_W-1:0] HALF_PERIOD [NUM_KEYS] = '{
    19'd382226, 19'd340524, 19'd303372, 19'd286346, 19'd255105, 19'd227273, 19'd202477,
    19'd191113, 19'd170262, 19'd151686, 19'd143173, 19'd127553, 19'd113636, 19'd101238,
    19'd95557,  19'd85131,  19'd75843,  19'd71586,  19'd63776,  19'd56818,  19'd50619
  };

  typedef enum logic {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } allocState_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Key-in / voice-out bundle between key scan, the allocator and the tone generators.
interface voice_allocator_if;
  import piano_pkg::*;

  logic [NUM_KEYS-1:0]         key;
  logic [NUM_VOICES-1:0]       voice_valid;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       voice_start;
  logic                        dropped;
  logic                        busy;

  modport master (
    output key,
    input  voice_valid, voice_key, voice_start, dropped, busy
  );

  modport slave (
    input  key,
    output voice_valid, voice_key, voice_start, dropped, busy
  );

endinterface

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit encoder: index of the lowest asserted request plus a found flag.
module prio_enc_lsb #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign found = |req;

endmodule

// File: rtl/voice_allocator.sv
// Maps held keys onto a small pool of shared tone voices, one allocation per cycle,
// lowest pending note first, no voice stealing.
//
//   state | meaning
//   IDLE  | no press waiting for a voice
//   ALLOC | servicing the lowest pending press this cycle
module voice_allocator
  import piano_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  voice_allocator_if.slave bus
);

  allocState_e state, stateNext;

  logic [NUM_KEYS-1:0]         keyQ, pending, pendingNext, pressEv;
  logic [NUM_VOICES-1:0]       voiceValid, validNext;
  logic [NUM_VOICES-1:0]       voiceStart, startNext;
  logic [NUM_VOICES*KEY_W-1:0] voiceKey, voiceKeyNext;
  logic                        droppedQ, droppedNext;

  logic [KEY_W-1:0]   selKey;
  logic               selFound;
  logic [VOICE_W-1:0] freeIdx;
  logic               freeFound;

  assign pressEv = bus.key & ~keyQ;

  prio_enc_lsb #(.WIDTH(NUM_KEYS), .IDX_W(KEY_W)) uPendSel (
    .req   (pending),
    .idx   (selKey),
    .found (selFound)
  );

  // Free select sees registered valids, so a voice released this cycle is not reusable yet.
  prio_enc_lsb #(.WIDTH(NUM_VOICES), .IDX_W(VOICE_W)) uFreeSel (
    .req   (~voiceValid),
    .idx   (freeIdx),
    .found (freeFound)
  );

  always_comb begin
    stateNext    = state;
    pendingNext  = pending | pressEv;
    validNext    = voiceValid;
    voiceKeyNext = voiceKey;
    startNext    = '0;
    droppedNext  = 1'b0;

    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voiceValid[v] && !bus.key[voiceKey[v*KEY_W +: KEY_W]]) validNext[v] = 1'b0;
    end

    case (state)
      IDLE: begin
        if (pendingNext != '0) stateNext = ALLOC;
      end
      ALLOC: begin
        if (selFound) begin
          // Cleared after the OR so a re-press of the serviced key merges into this service.
          pendingNext[selKey] = 1'b0;
          if (bus.key[selKey]) begin
            if (freeFound) begin
              validNext[freeIdx]                   = 1'b1;
              voiceKeyNext[freeIdx*KEY_W +: KEY_W] = selKey;
              startNext[freeIdx]                   = 1'b1;
            end else begin
              droppedNext = 1'b1;
            end
          end
        end
        if (pendingNext == '0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      keyQ       <= '0;
      pending    <= '0;
      voiceValid <= '0;
      voiceKey   <= '0;
      voiceStart <= '0;
      droppedQ   <= 1'b0;
    end else begin
      state      <= stateNext;
      keyQ       <= bus.key;
      pending    <= pendingNext;
      voiceValid <= validNext;
      voiceKey   <= voiceKeyNext;
      voiceStart <= startNext;
      droppedQ   <= droppedNext;
    end
  end

  assign bus.voice_valid = voiceValid;
  assign bus.voice_key   = voiceKey;
  assign bus.voice_start = voiceStart;
  assign bus.dropped     = droppedQ;
  assign bus.busy        = |pending;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator; expected values are hand-derived per scenario.
module tb_voice_allocator;
  import piano_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   invViol = 0;
  int   exclViol = 0;

  voice_allocator_if bus ();

  voice_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [KEY_W-1:0] vk(input int v);
    return bus.voice_key[v*KEY_W +: KEY_W];
  endfunction

  // Duplicate-note and start/dropped exclusivity monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int a = 0; a < NUM_VOICES; a++)
        for (int b = a + 1; b < NUM_VOICES; b++)
          if (bus.voice_valid[a] && bus.voice_valid[b] && vk(a) == vk(b)) invViol++;
      if ((bus.dropped && bus.voice_start != '0) || !$onehot0(bus.voice_start)) exclViol++;
    end
  end

  initial begin
    bus.key = '0;
    steps(2);
    checkVal("rst_valid", 32'(bus.voice_valid), 32'h0);
    checkVal("rst_vkey",  32'(bus.voice_key),   32'h0);
    checkVal("rst_start", 32'(bus.voice_start), 32'h0);
    checkVal("rst_drop",  32'(bus.dropped),     32'h0);
    checkVal("rst_busy",  32'(bus.busy),        32'h0);
    rst_n = 1'b1;
    step();

    // Single press of A4.
    bus.key[A4] = 1'b1;
    step();
    checkVal("a4_busy_e0",  32'(bus.busy),        32'h1);
    checkVal("a4_valid_e0", 32'(bus.voice_valid), 32'h0);
    step();
    checkVal("a4_valid_e1", 32'(bus.voice_valid), 32'h1);
    checkVal("a4_vk0",      32'(vk(0)),           32'd12);
    checkVal("a4_start_e1", 32'(bus.voice_start), 32'h1);
    checkVal("a4_busy_e1",  32'(bus.busy),        32'h0);
    step();
    checkVal("a4_start_e2", 32'(bus.voice_start), 32'h0);
    checkVal("a4_valid_e2", 32'(bus.voice_valid), 32'h1);
    bus.key = '0;
    step();
    checkVal("a4_rel_valid", 32'(bus.voice_valid), 32'h0);
    checkVal("a4_rel_vk0",   32'(vk(0)),           32'd12);

    // Three simultaneous presses serviced ascending.
    bus.key = '0;
    bus.key[0] = 1'b1; bus.key[7] = 1'b1; bus.key[14] = 1'b1;
    step();
    checkVal("tri_busy_e0", 32'(bus.busy), 32'h1);
    step();
    checkVal("tri_valid_e1", 32'(bus.voice_valid), 32'h1);
    checkVal("tri_vk0",      32'(vk(0)),           32'd0);
    checkVal("tri_start_e1", 32'(bus.voice_start), 32'h1);
    checkVal("tri_busy_e1",  32'(bus.busy),        32'h1);
    step();
    checkVal("tri_valid_e2", 32'(bus.voice_valid), 32'h3);
    checkVal("tri_vk1",      32'(vk(1)),           32'd7);
    checkVal("tri_start_e2", 32'(bus.voice_start), 32'h2);
    checkVal("tri_busy_e2",  32'(bus.busy),        32'h1);
    step();
    checkVal("tri_valid_e3", 32'(bus.voice_valid), 32'h7);
    checkVal("tri_vk2",      32'(vk(2)),           32'd14);
    checkVal("tri_start_e3", 32'(bus.voice_start), 32'h4);
    checkVal("tri_busy_e3",  32'(bus.busy),        32'h0);
    bus.key = '0;
    step();
    checkVal("tri_rel", 32'(bus.voice_valid), 32'h0);

    // Fill all voices, overflow press is dropped.
    bus.key = 21'h1E;
    steps(5);
    checkVal("full_valid", 32'(bus.voice_valid), 32'hF);
    checkVal("full_vkeys", 32'(bus.voice_key),   {12'h0, 5'd4, 5'd3, 5'd2, 5'd1});
    bus.key[5] = 1'b1;
    steps(2);
    checkVal("ovf_drop",  32'(bus.dropped),     32'h1);
    checkVal("ovf_start", 32'(bus.voice_start), 32'h0);
    checkVal("ovf_valid", 32'(bus.voice_valid), 32'hF);
    checkVal("ovf_vkeys", 32'(bus.voice_key),   {12'h0, 5'd4, 5'd3, 5'd2, 5'd1});
    step();
    checkVal("ovf_drop_off", 32'(bus.dropped), 32'h0);
    bus.key[2] = 1'b0; bus.key[5] = 1'b0;
    step();
    checkVal("k2_rel_valid", 32'(bus.voice_valid), 32'hD);
    bus.key[5] = 1'b1;
    steps(2);
    checkVal("k5_valid", 32'(bus.voice_valid), 32'hF);
    checkVal("k5_vk1",   32'(vk(1)),           32'd5);
    checkVal("k5_start", 32'(bus.voice_start), 32'h2);
    bus.key = '0;
    step();

    // Key 20 released before its slot: only key 3 allocated.
    bus.key[20] = 1'b1; bus.key[3] = 1'b1;
    step();
    bus.key[20] = 1'b0;
    step();
    checkVal("skip_valid_e1", 32'(bus.voice_valid), 32'h1);
    checkVal("skip_vk0",      32'(vk(0)),           32'd3);
    step();
    checkVal("skip_valid_e2", 32'(bus.voice_valid), 32'h1);
    checkVal("skip_start_e2", 32'(bus.voice_start), 32'h0);
    checkVal("skip_drop_e2",  32'(bus.dropped),     32'h0);
    checkVal("skip_busy_e2",  32'(bus.busy),        32'h0);
    bus.key = '0;
    step();

    // Release on the same edge a press finds all voices busy.
    bus.key = 21'h1E;
    steps(5);
    bus.key[6] = 1'b1;
    step();
    bus.key[1] = 1'b0;
    step();
    checkVal("race_drop",  32'(bus.dropped),     32'h1);
    checkVal("race_valid", 32'(bus.voice_valid), 32'hE);
    bus.key[8] = 1'b1;
    steps(2);
    checkVal("race_new_valid", 32'(bus.voice_valid), 32'hF);
    checkVal("race_new_vk0",   32'(vk(0)),           32'd8);
    checkVal("race_new_start", 32'(bus.voice_start), 32'h1);
    bus.key = '0;
    step();

    // Reset mid-allocation, keys still held afterwards.
    bus.key[2] = 1'b1; bus.key[9] = 1'b1; bus.key[15] = 1'b1;
    steps(2);
    checkVal("mid_valid_pre", 32'(bus.voice_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    checkVal("mid_rst_valid", 32'(bus.voice_valid), 32'h0);
    checkVal("mid_rst_vkey",  32'(bus.voice_key),   32'h0);
    checkVal("mid_rst_busy",  32'(bus.busy),        32'h0);
    checkVal("mid_rst_start", 32'(bus.voice_start), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    checkVal("post_busy_e0",  32'(bus.busy),        32'h1);
    checkVal("post_valid_e0", 32'(bus.voice_valid), 32'h0);
    step();
    checkVal("post_vk0", 32'(vk(0)), 32'd2);
    step();
    checkVal("post_vk1", 32'(vk(1)), 32'd9);
    step();
    checkVal("post_vk2",    32'(vk(2)),           32'd15);
    checkVal("post_valid",  32'(bus.voice_valid), 32'h7);
    checkVal("post_busy",   32'(bus.busy),        32'h0);
    bus.key = '0;
    steps(2);

    checkVal("dup_note_invariant", 32'(invViol),  32'h0);
    checkVal("start_drop_excl",    32'(exclViol), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
